// File: rtl/ov9281_pkg.sv
// ov9281_pkg
// Shared types and constants for the OV9281 SCCB arbiter slice.
//   sccb_cmd_t   : one register access {rw, addr, wdata}
//   arb_state_e  : arbiter FSM states
//   sccb_slave() : 8-bit bus address for a given direction
package ov9281_pkg;

  localparam logic [7:0]  OV9281_SLAVE_ADDR    = 8'hC0;
  localparam logic [15:0] OV9281_REG_CHIP_ID_H = 16'h300A;
  localparam logic [15:0] OV9281_REG_CHIP_ID_L = 16'h300B;
  localparam logic [15:0] OV9281_REG_MODE_SEL  = 16'h0100;

  typedef struct packed {
    logic        rw;     // 0 = write, 1 = read
    logic [15:0] addr;
    logic [7:0]  wdata;
  } sccb_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BACKOFF,
    ST_COMPLETE
  } arb_state_e;

  // Read address is the write address with the LSB set.
  function automatic logic [7:0] sccb_slave(input logic [7:0] base, input logic rw);
    return base | {7'b0, rw};
  endfunction

endpackage

// File: rtl/ov9281_rr_pick.sv
// ov9281_rr_pick
// Combinational one-hot picker. With PRIO0 set, port 0 wins whenever it
// requests; otherwise the first requester at or after ptr_i (wrapping) wins.
//   req_i : request vector
//   ptr_i : round-robin start index (must be < N_REQ)
//   gnt_o : one-hot winner, zero when nothing requests
//   idx_o : binary winner index
//   any_o : at least one request present
module ov9281_rr_pick #(
  parameter int N_REQ = 3,
  parameter int PRIO0 = 1,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    k     = '0;
    if (PRIO0 != 0 && req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        k = IW'((int'(ptr_i) + i) % N_REQ);
        if (!found && req_i[k]) begin
          found    = 1'b1;
          gnt_o[k] = 1'b1;
          idx_o    = k;
        end
      end
    end
  end

endmodule

// File: rtl/ov9281_sccb_arbiter.sv
// ov9281_sccb_arbiter
// Shares one SCCB/I2C master between N_REQ requesters. Each requester posts a
// single register read/write; the winner's command is latched, issued to the
// engine, retried on NACK / arbitration loss with an idle gap, and aborted on
// timeout. Completion is reported with a one-hot done pulse plus err/rdata.
//   clk, i_rst            : clock, synchronous active-high reset
//   i_req/_rw/_addr/_wdata: per-port request level and command fields
//   o_req_gnt             : one-hot pulse, command latched
//   o_req_done/err, o_rdata: one-hot completion pulse with status and read data
//   o_mst_*               : command port to the I2C engine (start pulse + held fields)
//   i_mst_*               : engine status (busy, done pulse, nack, arb_lost, rdata)
//   o_busy                : arbiter not idle
module ov9281_sccb_arbiter
  import ov9281_pkg::*;
#(
  parameter int          N_REQ       = 3,
  parameter int          PRIO0       = 1,
  parameter logic [7:0]  SLAVE_ADDR  = OV9281_SLAVE_ADDR,
  parameter int          MAX_RETRY   = 3,
  parameter int          RETRY_GAP   = 1000,   // >= 1
  parameter int          TIMEOUT_CYC = 2000000 // >= 2
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ-1:0]      i_req_rw,
  input  logic [16*N_REQ-1:0]   i_req_addr,
  input  logic [8*N_REQ-1:0]    i_req_wdata,
  output logic [N_REQ-1:0]      o_req_gnt,
  output logic [N_REQ-1:0]      o_req_done,
  output logic                  o_req_err,
  output logic [7:0]            o_rdata,
  output logic                  o_mst_start,
  output logic                  o_mst_rw,
  output logic [7:0]            o_mst_slave,
  output logic [15:0]           o_mst_addr,
  output logic [7:0]            o_mst_wdata,
  input  logic                  i_mst_busy,
  input  logic                  i_mst_done,
  input  logic                  i_mst_nack,
  input  logic                  i_mst_arb_lost,
  input  logic [7:0]            i_mst_rdata,
  output logic                  o_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(RETRY_GAP + 1);

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);

  arb_state_e       state_q, state_d;
  sccb_cmd_t        cmd_q, cmd_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             start_q, start_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [15:0] addr_a  [N_REQ];
  logic [7:0]  wdata_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = i_req_addr[16*g +: 16];
    assign wdata_a[g] = i_req_wdata[8*g +: 8];
  end

  ov9281_rr_pick #(
    .N_REQ (N_REQ),
    .PRIO0 (PRIO0)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !i_mst_busy) begin
          win_d       = pick_idx;
          gnt_d       = pick_gnt;
          cmd_d.rw    = i_req_rw[pick_idx];
          cmd_d.addr  = addr_a[pick_idx];
          cmd_d.wdata = wdata_a[pick_idx];
          ptr_d       = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mst_done) begin
          // nack and arb_lost together still count as one retry event
          if (i_mst_nack || i_mst_arb_lost) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              gap_d   = '0;
              state_d = ST_BACKOFF;
            end else begin
              err_d   = 1'b1;
              rdata_d = '0;
              state_d = ST_COMPLETE;
            end
          end else begin
            err_d   = 1'b0;
            rdata_d = cmd_q.rw ? i_mst_rdata : 8'h00;
            state_d = ST_COMPLETE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_COMPLETE;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (gap_q == GAP_LAST) begin
          if (!i_mst_busy) state_d = ST_ISSUE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_COMPLETE: begin
        retry_d = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
    end
  end

  logic active;
  logic complete;

  assign active   = (state_q != ST_IDLE);
  assign complete = (state_q == ST_COMPLETE);

  assign o_req_gnt   = gnt_q;
  assign o_req_done  = complete ? (N_REQ'(1) << win_q) : '0;
  assign o_req_err   = complete & err_q;
  assign o_rdata     = complete ? rdata_q : 8'h00;
  assign o_mst_start = start_q;
  assign o_mst_rw    = active & cmd_q.rw;
  assign o_mst_slave = active ? sccb_slave(SLAVE_ADDR, cmd_q.rw) : 8'h00;
  assign o_mst_addr  = active ? cmd_q.addr : 16'h0000;
  assign o_mst_wdata = active ? cmd_q.wdata : 8'h00;
  assign o_busy      = active;

endmodule
